// File: rtl/step_bcd_seq.sv
// Sequential binary-to-BCD converter for the step / target-step text renderer.
// Optional build macro: LEADING_BLANK_EN (suppress leading zero digits as 4'hF).
module step_bcd_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] step_exp,
    output logic [3:0]       hundred,
    output logic [3:0]       ten,
    output logic [3:0]       one,
    output logic [3:0]       hundred_exp,
    output logic [3:0]       ten_exp,
    output logic [3:0]       one_exp,
    output logic             busy,
    output logic             upd
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] last_s, last_e;
    logic [WIDTH-1:0] lat_s, lat_e;
    logic [WIDTH-1:0] bin_s, bin_e;
    logic [11:0]      scr_s, scr_e;
    logic [11:0]      adj_s, adj_e;
    logic [11:0]      dig_s, dig_e;
    logic             ovf_s, ovf_e;
    logic [CW-1:0]    cnt;
    logic             start;
    logic             last_bit;

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    function automatic logic [11:0] dabble_adj(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int d = 0; d < 3; d++) begin
            if (s[4*d +: 4] >= 4'd5) r[4*d +: 4] = s[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [11:0] render(input logic [11:0] s, input logic ovf);
        logic [11:0] r;
        r = s;
        if (ovf) r = 12'hFFF;
`ifdef LEADING_BLANK_EN
        else if (s[11:8] == 4'd0) begin
            r[11:8] = 4'hF;
            if (s[7:4] == 4'd0) r[7:4] = 4'hF;
        end
`endif
        return r;
    endfunction

    assign start    = {step, step_exp} != {last_s, last_e};
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign adj_s    = dabble_adj(scr_s);
    assign adj_e    = dabble_adj(scr_e);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_s <= '0;
            last_e <= '0;
            lat_s  <= '0;
            lat_e  <= '0;
            bin_s  <= '0;
            bin_e  <= '0;
            scr_s  <= '0;
            scr_e  <= '0;
            ovf_s  <= 1'b0;
            ovf_e  <= 1'b0;
            cnt    <= '0;
            dig_s  <= '0;
            dig_e  <= '0;
            busy   <= 1'b0;
            upd    <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_s <= step;
                        lat_e <= step_exp;
                        bin_s <= step;
                        bin_e <= step_exp;
                        scr_s <= '0;
                        scr_e <= '0;
                        ovf_s <= 1'b0;
                        ovf_e <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    // A 1 leaving the hundreds digit means the value exceeded 999.
                    scr_s <= {adj_s[10:0], bin_s[WIDTH-1]};
                    scr_e <= {adj_e[10:0], bin_e[WIDTH-1]};
                    bin_s <= bin_s << 1;
                    bin_e <= bin_e << 1;
                    ovf_s <= ovf_s | adj_s[11];
                    ovf_e <= ovf_e | adj_e[11];
                    cnt   <= cnt + CW'(1);
                end
                DONE: begin
                    dig_s  <= render(scr_s, ovf_s);
                    dig_e  <= render(scr_e, ovf_e);
                    last_s <= lat_s;
                    last_e <= lat_e;
                    busy   <= 1'b0;
                    upd    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hundred     = dig_s[11:8];
    assign ten         = dig_s[7:4];
    assign one         = dig_s[3:0];
    assign hundred_exp = dig_e[11:8];
    assign ten_exp     = dig_e[7:4];
    assign one_exp     = dig_e[3:0];

endmodule

// File: tb/tb_step_bcd_seq.sv
// Bench for step_bcd_seq: 8-bit instance for timing/digit checks, 10-bit instance for overflow.
// Honours LEADING_BLANK_EN in its decimal reference model.
module tb_step_bcd_seq;

    localparam int W   = 8;
    localparam int W10 = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [W-1:0] step = '0, step_exp = '0;
    logic [3:0] hundred, ten, one, hundred_exp, ten_exp, one_exp;
    logic busy, upd;
    logic [W10-1:0] s10 = '0, e10 = '0;
    logic [3:0] h10, t10, o10, he10, te10, oe10;
    logic busy10, upd10;
    logic [23:0] dig, dig10;

    int tests  = 0;
    int failed = 0;

    // Scoreboard: last converted inputs and the digits the renderer should see.
    logic [W-1:0] ms = '0, me = '0;
    logic [23:0]  cur_d = '0;

    logic         busy_tr[64];
    logic         upd_tr[64];
    logic [23:0]  dig_tr[64];

    logic [W-1:0] dir_s[7] = '{8'd0, 8'd123, 8'd255, 8'd254, 8'd7, 8'd40, 8'd0};
    logic [W-1:0] dir_e[7] = '{8'd0, 8'd45,  8'd0,   8'd0,   8'd0, 8'd99, 8'd0};

    step_bcd_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .step(step), .step_exp(step_exp),
        .hundred(hundred), .ten(ten), .one(one),
        .hundred_exp(hundred_exp), .ten_exp(ten_exp), .one_exp(one_exp),
        .busy(busy), .upd(upd)
    );

    step_bcd_seq #(.WIDTH(W10)) dut10 (
        .clk(clk), .rst(rst), .step(s10), .step_exp(e10),
        .hundred(h10), .ten(t10), .one(o10),
        .hundred_exp(he10), .ten_exp(te10), .one_exp(oe10),
        .busy(busy10), .upd(upd10)
    );

    assign dig   = {hundred, ten, one, hundred_exp, ten_exp, one_exp};
    assign dig10 = {h10, t10, o10, he10, te10, oe10};

    always #5 clk = ~clk;

    // Decimal reference: plain division, FFF above 999, optional leading blanks.
    function automatic logic [11:0] model(input int v);
        logic [3:0] h, t, o;
        if (v > 999) return 12'hFFF;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
`ifdef LEADING_BLANK_EN
        if (h == 4'd0) begin
            h = 4'hF;
            if (t == 4'd0) t = 4'hF;
        end
`endif
        return {h, t, o};
    endfunction

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            busy_tr[i] = busy;
            upd_tr[i]  = upd;
            dig_tr[i]  = dig;
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({dig, busy, upd, dig10, busy10, upd10} !== 52'd0) begin
            failed++;
            $display("FAIL reset_state got dig=%h busy=%b upd=%b dig10=%h exp all zero", dig, busy, upd, dig10);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        watch(20);
        for (int i = 0; i < 20; i++) begin
            tests++;
            if ({busy_tr[i], upd_tr[i], dig_tr[i]} !== 26'd0) begin
                failed++;
                $display("FAIL idle_zero cyc=%0d got busy=%b upd=%b dig=%h exp 0/0/000000", i, busy_tr[i], upd_tr[i], dig_tr[i]);
            end
        end
    endtask

    task automatic test_convert;
        logic [W-1:0] s, e;
        logic changed, expb, expu;
        logic [23:0] old_d, new_d, expd;
        for (int t = 0; t < 26; t++) begin
            if (t < 7) begin
                s = dir_s[t];
                e = dir_e[t];
            end else if ($urandom_range(0, 4) == 0) begin
                s = ms;
                e = me;
            end else begin
                s = W'($urandom_range(0, (1 << W) - 1));
                e = W'($urandom_range(0, (1 << W) - 1));
            end
            changed = ({s, e} != {ms, me});
            old_d = cur_d;
            new_d = {model(int'(s)), model(int'(e))};
            @(negedge clk);
            step = s;
            step_exp = e;
            watch(W + 3);
            for (int i = 0; i < W + 3; i++) begin
                expb = changed && (i <= W);
                expu = changed && (i == W + 1);
                expd = (changed && i >= W + 1) ? new_d : old_d;
                tests++;
                if ({busy_tr[i], upd_tr[i], dig_tr[i]} !== {expb, expu, expd}) begin
                    failed++;
                    $display("FAIL conv s=%0d e=%0d cyc=%0d got busy=%b upd=%b dig=%h exp busy=%b upd=%b dig=%h",
                             s, e, i, busy_tr[i], upd_tr[i], dig_tr[i], expb, expu, expd);
                end
            end
            if (changed) begin
                ms = s;
                me = e;
                cur_d = new_d;
            end
        end
    endtask

    task automatic test_midchange;
        logic [23:0] old_d, d10, d99, expd;
        logic expb, expu;
        @(negedge clk);
        step = W'(200);
        watch(W + 3);
        ms = W'(200);
        cur_d = {model(200), model(int'(me))};
        old_d = cur_d;
        d10 = {model(10), model(int'(me))};
        d99 = {model(99), model(int'(me))};
        @(negedge clk);
        step = W'(10);
        for (int i = 0; i < 2 * W + 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            expb = (i <= W) || (i >= W + 2 && i <= 2 * W + 2);
            expu = (i == W + 1) || (i == 2 * W + 3);
            expd = (i < W + 1) ? old_d : (i < 2 * W + 3) ? d10 : d99;
            tests++;
            if ({busy, upd, dig} !== {expb, expu, expd}) begin
                failed++;
                $display("FAIL midchange cyc=%0d got busy=%b upd=%b dig=%h exp busy=%b upd=%b dig=%h",
                         i, busy, upd, dig, expb, expu, expd);
            end
            if (i == 2) step = W'(99);
        end
        ms = W'(99);
        cur_d = d99;
    endtask

    task automatic test_glitch;
        logic [W-1:0] s1;
        logic [23:0] old_d, new_d, expd;
        logic expb, expu;
        @(negedge clk);
        step = ms ^ W'(1);
        #2 step = ms;
        watch(W + 3);
        for (int i = 0; i < W + 3; i++) begin
            tests++;
            if ({busy_tr[i], upd_tr[i], dig_tr[i]} !== {2'b00, cur_d}) begin
                failed++;
                $display("FAIL idle_glitch cyc=%0d got busy=%b upd=%b dig=%h exp busy=0 upd=0 dig=%h",
                         i, busy_tr[i], upd_tr[i], dig_tr[i], cur_d);
            end
        end
        s1 = ms ^ W'(90);
        old_d = cur_d;
        new_d = {model(int'(s1)), model(int'(me))};
        @(negedge clk);
        step = s1;
        for (int i = 0; i < W + 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            expb = (i <= W);
            expu = (i == W + 1);
            expd = (i >= W + 1) ? new_d : old_d;
            tests++;
            if ({busy, upd, dig} !== {expb, expu, expd}) begin
                failed++;
                $display("FAIL shift_glitch cyc=%0d got busy=%b upd=%b dig=%h exp busy=%b upd=%b dig=%h",
                         i, busy, upd, dig, expb, expu, expd);
            end
            if (i == 1) step = s1 ^ W'(1);
            if (i == 4) step = s1;
        end
        ms = s1;
        cur_d = new_d;
    endtask

    task automatic test_reset_mid;
        logic [23:0] new_d, expd;
        logic expb, expu;
        @(negedge clk);
        step = W'(50);
        step_exp = W'(0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, upd, dig} !== 26'd0) begin
            failed++;
            $display("FAIL reset_mid got busy=%b upd=%b dig=%h exp busy=0 upd=0 dig=000000", busy, upd, dig);
        end
        @(negedge clk);
        rst = 1'b0;
        ms = '0;
        me = '0;
        cur_d = '0;
        new_d = {model(50), model(0)};
        watch(W + 3);
        for (int i = 0; i < W + 3; i++) begin
            expb = (i <= W);
            expu = (i == W + 1);
            expd = (i >= W + 1) ? new_d : 24'd0;
            tests++;
            if ({busy_tr[i], upd_tr[i], dig_tr[i]} !== {expb, expu, expd}) begin
                failed++;
                $display("FAIL after_reset cyc=%0d got busy=%b upd=%b dig=%h exp busy=%b upd=%b dig=%h",
                         i, busy_tr[i], upd_tr[i], dig_tr[i], expb, expu, expd);
            end
        end
        ms = W'(50);
        cur_d = new_d;
    endtask

    task automatic test_wide;
        int vs[8];
        int ve[8];
        logic [W10-1:0] l10s, l10e;
        logic [23:0] old_d, new_d, expd;
        logic changed, expb, expu;
        vs = '{1000, 999, 1023, 500, 0, 0, 0, 0};
        ve = '{999, 1000, 0, 7, 0, 0, 0, 0};
        for (int t = 4; t < 8; t++) begin
            vs[t] = $urandom_range(0, 1023);
            ve[t] = $urandom_range(0, 1023);
        end
        l10s = '0;
        l10e = '0;
        old_d = '0;
        for (int t = 0; t < 8; t++) begin
            changed = ({W10'(vs[t]), W10'(ve[t])} != {l10s, l10e});
            new_d = {model(vs[t]), model(ve[t])};
            @(negedge clk);
            s10 = W10'(vs[t]);
            e10 = W10'(ve[t]);
            for (int i = 0; i < W10 + 3; i++) begin
                @(posedge clk);
                @(negedge clk);
                expb = changed && (i <= W10);
                expu = changed && (i == W10 + 1);
                expd = (changed && i >= W10 + 1) ? new_d : old_d;
                tests++;
                if ({busy10, upd10, dig10} !== {expb, expu, expd}) begin
                    failed++;
                    $display("FAIL wide s=%0d e=%0d cyc=%0d got busy=%b upd=%b dig=%h exp busy=%b upd=%b dig=%h",
                             vs[t], ve[t], i, busy10, upd10, dig10, expb, expu, expd);
                end
            end
            if (changed) begin
                l10s = W10'(vs[t]);
                l10e = W10'(ve[t]);
                old_d = new_d;
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_midchange();
        test_glitch();
        test_reset_mid();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
